// File: rtl/sy_ppl_spec_ras_if.sv
// Predictor-side bundle for the speculative return-address stack.
// CKPT_W gains the recursion-counter field when SY_RAS_RCNT_EN is defined.
interface sy_ppl_spec_ras_if #(
    parameter int DEPTH  = 8,
    parameter int AWTH   = 32,
    parameter int RCNT_W = 2
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef SY_RAS_RCNT_EN
    localparam int CKPT_W = CNT_W + PTR_W + AWTH + RCNT_W;
`else
    localparam int CKPT_W = CNT_W + PTR_W + AWTH;
`endif

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (RCNT_W < 1)) begin : g_bad_cfg
        $error("sy_ppl_spec_ras_if: DEPTH must be a power of two >= 2 and RCNT_W >= 1");
    end

    logic              flush_i;
    logic              push_i;
    logic              pop_i;
    logic [AWTH-1:0]   data_i;
    logic              restore_i;
    logic [CKPT_W-1:0] restore_ckpt_i;
    logic              top_vld_o;
    logic [AWTH-1:0]   top_ra_o;
    logic [CKPT_W-1:0] ckpt_o;

    modport master (
        output flush_i, push_i, pop_i, data_i, restore_i, restore_ckpt_i,
        input  top_vld_o, top_ra_o, ckpt_o
    );

    modport slave (
        input  flush_i, push_i, pop_i, data_i, restore_i, restore_ckpt_i,
        output top_vld_o, top_ra_o, ckpt_o
    );
endinterface

// File: rtl/sy_ppl_spec_ras.sv
// Speculative return-address stack with checkpoint/restore; recursion counters under SY_RAS_RCNT_EN.
// Requests land on the next edge, outputs come only from registered state; no backpressure.
module sy_ppl_spec_ras #(
    parameter int DEPTH  = 8,
    parameter int AWTH   = 32,
    parameter int RCNT_W = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    sy_ppl_spec_ras_if.slave      ras
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef SY_RAS_RCNT_EN
    localparam int RC_OFF = RCNT_W;
`else
    localparam int RC_OFF = 0;
`endif
    localparam int CKPT_W = CNT_W + PTR_W + AWTH + RC_OFF;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (RCNT_W < 1)) begin : g_bad_cfg
        $error("sy_ppl_spec_ras: DEPTH must be a power of two >= 2 and RCNT_W >= 1");
    end

    logic [AWTH-1:0]  r_ra [DEPTH];
    logic [PTR_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_cnt;

    logic [PTR_W-1:0] w_ptr_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_wr_en;
    logic [PTR_W-1:0] w_wr_idx;
    logic [AWTH-1:0]  w_wr_ra;
    logic [AWTH-1:0]  w_top_ra;
    logic             w_nonempty;
    logic [PTR_W-1:0] w_ptr_inc;
    logic [PTR_W-1:0] w_ptr_dec;
    logic [CNT_W-1:0] w_ck_cnt;
    logic [PTR_W-1:0] w_ck_ptr;
    logic [AWTH-1:0]  w_ck_ra;

    assign w_top_ra   = r_ra[r_ptr];
    assign w_nonempty = (r_cnt != '0);
    assign w_ptr_inc  = r_ptr + 1'b1;
    assign w_ptr_dec  = r_ptr - 1'b1;

    assign w_ck_cnt = ras.restore_ckpt_i[CKPT_W-1 -: CNT_W];
    assign w_ck_ptr = ras.restore_ckpt_i[CKPT_W-CNT_W-1 -: PTR_W];
    assign w_ck_ra  = ras.restore_ckpt_i[RC_OFF+AWTH-1 -: AWTH];

`ifdef SY_RAS_RCNT_EN
    localparam logic [RCNT_W-1:0] RCNT_MAX = '1;

    logic [RCNT_W-1:0] r_rcnt [DEPTH];
    logic [RCNT_W-1:0] w_wr_rcnt;
    logic [RCNT_W-1:0] w_top_rcnt;
    logic [RCNT_W-1:0] w_ck_rcnt;

    assign w_top_rcnt = r_rcnt[r_ptr];
    assign w_ck_rcnt  = ras.restore_ckpt_i[RCNT_W-1:0];
    assign ras.ckpt_o = {r_cnt, r_ptr, w_top_ra, w_top_rcnt};
`else
    assign ras.ckpt_o = {r_cnt, r_ptr, w_top_ra};
`endif

    assign ras.top_vld_o = w_nonempty;
    assign ras.top_ra_o  = w_nonempty ? w_top_ra : '0;

    always_comb begin
        w_ptr_nxt = r_ptr;
        w_cnt_nxt = r_cnt;
        w_wr_en   = 1'b0;
        w_wr_idx  = r_ptr;
        w_wr_ra   = ras.data_i;
`ifdef SY_RAS_RCNT_EN
        w_wr_rcnt = '0;
`endif
        if (ras.restore_i) begin
            // Only the snapshotted top entry is repaired; deeper slots keep whatever is there.
            w_ptr_nxt = w_ck_ptr;
            w_cnt_nxt = w_ck_cnt;
            w_wr_en   = 1'b1;
            w_wr_idx  = w_ck_ptr;
            w_wr_ra   = w_ck_ra;
`ifdef SY_RAS_RCNT_EN
            w_wr_rcnt = w_ck_rcnt;
`endif
        end else if (ras.push_i && ras.pop_i) begin
            w_wr_en = 1'b1;
            if (!w_nonempty) begin
                w_cnt_nxt = CNT_W'(1);
            end
        end else if (ras.push_i) begin
`ifdef SY_RAS_RCNT_EN
            if (w_nonempty && (ras.data_i == w_top_ra) && (w_top_rcnt != RCNT_MAX)) begin
                w_wr_en   = 1'b1;
                w_wr_ra   = w_top_ra;
                w_wr_rcnt = w_top_rcnt + 1'b1;
            end else
`endif
            begin
                w_ptr_nxt = w_ptr_inc;
                w_wr_en   = 1'b1;
                w_wr_idx  = w_ptr_inc;
                if (r_cnt != CNT_W'(DEPTH)) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
        end else if (ras.pop_i && w_nonempty) begin
`ifdef SY_RAS_RCNT_EN
            if (w_top_rcnt != '0) begin
                w_wr_en   = 1'b1;
                w_wr_ra   = w_top_ra;
                w_wr_rcnt = w_top_rcnt - 1'b1;
            end else
`endif
            begin
                w_ptr_nxt = w_ptr_dec;
                w_cnt_nxt = r_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || ras.flush_i) begin
            r_ptr <= '0;
            r_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_ra[i] <= '0;
`ifdef SY_RAS_RCNT_EN
                r_rcnt[i] <= '0;
`endif
            end
        end else begin
            r_ptr <= w_ptr_nxt;
            r_cnt <= w_cnt_nxt;
            if (w_wr_en) begin
                r_ra[w_wr_idx] <= w_wr_ra;
`ifdef SY_RAS_RCNT_EN
                r_rcnt[w_wr_idx] <= w_wr_rcnt;
`endif
            end
        end
    end
endmodule

// File: tb/tb_sy_ppl_spec_ras.sv
// Bench for sy_ppl_spec_ras: directed scenarios plus random traffic against a stack model.
module tb_sy_ppl_spec_ras;
    localparam int D   = 4;
    localparam int AW  = 16;
    localparam int RW  = 2;
    localparam int PW  = 2;
    localparam int CW  = 3;
`ifdef SY_RAS_RCNT_EN
    localparam int CKW = CW + PW + AW + RW;
    localparam bit RC_ON = 1'b1;
`else
    localparam int CKW = CW + PW + AW;
    localparam bit RC_ON = 1'b0;
`endif
    localparam int RC_MAX = (1 << RW) - 1;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    sy_ppl_spec_ras_if #(.DEPTH(D), .AWTH(AW), .RCNT_W(RW)) ras_if ();

    sy_ppl_spec_ras #(.DEPTH(D), .AWTH(AW), .RCNT_W(RW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .ras   (ras_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [CW-1:0] o_cnt;
    assign o_cnt = ras_if.ckpt_o[CKW-1 -: CW];

    // Reference stack: plain arrays and modular arithmetic straight from the stack rules.
    logic [AW-1:0] m_ra [D];
    int            m_rc [D];
    int            m_ptr;
    int            m_cnt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [CKW-1:0] m_ckpt();
`ifdef SY_RAS_RCNT_EN
        return {CW'(m_cnt), PW'(m_ptr), m_ra[m_ptr], RW'(m_rc[m_ptr])};
`else
        return {CW'(m_cnt), PW'(m_ptr), m_ra[m_ptr]};
`endif
    endfunction

    task automatic m_clear();
        m_ptr = 0;
        m_cnt = 0;
        for (int i = 0; i < D; i++) begin
            m_ra[i] = '0;
            m_rc[i] = 0;
        end
    endtask

    task automatic m_apply(input bit r, input bit f, input bit pu, input bit po,
                           input logic [AW-1:0] d, input bit rs, input logic [CKW-1:0] ck);
        if (r || f) begin
            m_clear();
        end else if (rs) begin
            m_cnt = int'(ck[CKW-1 -: CW]);
            m_ptr = int'(ck[CKW-CW-1 -: PW]);
`ifdef SY_RAS_RCNT_EN
            m_ra[m_ptr] = ck[RW+AW-1 -: AW];
            m_rc[m_ptr] = int'(ck[RW-1:0]);
`else
            m_ra[m_ptr] = ck[AW-1:0];
`endif
        end else if (pu && po) begin
            m_ra[m_ptr] = d;
            m_rc[m_ptr] = 0;
            if (m_cnt == 0) m_cnt = 1;
        end else if (pu) begin
            if (RC_ON && m_cnt > 0 && d == m_ra[m_ptr] && m_rc[m_ptr] < RC_MAX) begin
                m_rc[m_ptr] = m_rc[m_ptr] + 1;
            end else begin
                m_ptr = (m_ptr + 1) % D;
                m_ra[m_ptr] = d;
                m_rc[m_ptr] = 0;
                m_cnt = (m_cnt + 1 > D) ? D : m_cnt + 1;
            end
        end else if (po && m_cnt > 0) begin
            if (RC_ON && m_rc[m_ptr] > 0) begin
                m_rc[m_ptr] = m_rc[m_ptr] - 1;
            end else begin
                m_ptr = (m_ptr + D - 1) % D;
                m_cnt = m_cnt - 1;
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".vld"},  64'(ras_if.top_vld_o), 64'(m_cnt != 0));
        chk({tag, ".ra"},   64'(ras_if.top_ra_o),  (m_cnt != 0) ? 64'(m_ra[m_ptr]) : 64'd0);
        chk({tag, ".ckpt"}, 64'(ras_if.ckpt_o),    64'(m_ckpt()));
    endtask

    task automatic drive(input string tag, input bit r, input bit f, input bit pu, input bit po,
                         input logic [AW-1:0] d, input bit rs, input logic [CKW-1:0] ck);
        rst                   = r;
        ras_if.flush_i        = f;
        ras_if.push_i         = pu;
        ras_if.pop_i          = po;
        ras_if.data_i         = d;
        ras_if.restore_i      = rs;
        ras_if.restore_ckpt_i = ck;
        @(posedge clk);
        m_apply(r, f, pu, po, d, rs, ck);
        #1;
        check_model(tag);
    endtask

    task automatic do_push(input logic [AW-1:0] d);
        drive("push", 0, 0, 1, 0, d, 0, '0);
    endtask
    task automatic do_pop();
        drive("pop", 0, 0, 0, 1, '0, 0, '0);
    endtask
    task automatic do_flush();
        drive("flush", 0, 1, 0, 0, '0, 0, '0);
    endtask

    logic [CKW-1:0] snap;
    logic [CKW-1:0] hist[$];
    logic [AW-1:0]  pops_exp [4];

    initial begin
        n_chk  = 0;
        n_fail = 0;
        m_clear();
        drive("reset", 1, 0, 0, 0, '0, 0, '0);
        chk("rst_vld",  64'(ras_if.top_vld_o), 64'd0);
        chk("rst_ra",   64'(ras_if.top_ra_o),  64'd0);
        chk("rst_ckpt", 64'(ras_if.ckpt_o),    64'd0);

        do_push(16'h0100);
        do_push(16'h0200);
        chk("basic_top", 64'(ras_if.top_ra_o), 64'h200);
        do_pop();
        chk("basic_pop_top", 64'(ras_if.top_ra_o), 64'h100);
        chk("basic_pop_vld", 64'(ras_if.top_vld_o), 64'd1);

        // Overflow wraps over the oldest entry.
        do_flush();
        for (int i = 1; i <= 5; i++) do_push(AW'(i * 16));
        chk("ovf_cnt", 64'(o_cnt), 64'd4);
        chk("ovf_top", 64'(ras_if.top_ra_o), 64'h50);
        pops_exp[0] = 16'h50; pops_exp[1] = 16'h40; pops_exp[2] = 16'h30; pops_exp[3] = 16'h20;
        for (int i = 0; i < 4; i++) begin
            chk("ovf_pop_ret", 64'(ras_if.top_ra_o), 64'(pops_exp[i]));
            do_pop();
        end
        do_pop();
        chk("empty_cnt", 64'(o_cnt), 64'd0);
        chk("empty_vld", 64'(ras_if.top_vld_o), 64'd0);

        do_push(16'h10); do_push(16'h20); do_push(16'h30);
        drive("pushpop", 0, 0, 1, 1, 16'h00AA, 0, '0);
        chk("pp_top", 64'(ras_if.top_ra_o), 64'hAA);
        chk("pp_cnt", 64'(o_cnt), 64'd3);
        do_flush();
        drive("pushpop_empty", 0, 0, 1, 1, 16'h00AA, 0, '0);
        chk("ppe_cnt", 64'(o_cnt), 64'd1);
        chk("ppe_top", 64'(ras_if.top_ra_o), 64'hAA);

        // Checkpoint, wrong-path activity, then repair with a concurrent push.
        do_flush();
        do_push(16'h10); do_push(16'h20);
        snap = m_ckpt();
        chk("snap", 64'(ras_if.ckpt_o), 64'(snap));
        do_push(16'h70); do_pop(); do_pop();
        drive("restore", 0, 0, 1, 0, 16'h0099, 1, snap);
        chk("rs_top", 64'(ras_if.top_ra_o), 64'h20);
        chk("rs_cnt", 64'(o_cnt), 64'd2);

        drive("flush_push", 0, 1, 1, 0, 16'h0055, 0, '0);
        chk("fp_vld", 64'(ras_if.top_vld_o), 64'd0);
        chk("fp_cnt", 64'(o_cnt), 64'd0);
        do_push(16'h33);
        drive("rst_restore", 1, 0, 0, 0, '0, 1, snap);
        chk("rr_ckpt", 64'(ras_if.ckpt_o), 64'd0);

        // Repeated identical return addresses.
        do_flush();
        for (int i = 0; i < 5; i++) do_push(16'h0040);
`ifdef SY_RAS_RCNT_EN
        chk("rec_cnt", 64'(o_cnt), 64'd2);
        do_pop();
        chk("rec_rcnt", 64'(ras_if.ckpt_o[RW-1:0]), 64'd3);
        for (int i = 0; i < 4; i++) begin
            chk("rec_pop_ret", 64'(ras_if.top_ra_o), 64'h40);
            do_pop();
        end
        chk("rec_empty", 64'(ras_if.top_vld_o), 64'd0);
`else
        chk("rec_cnt", 64'(o_cnt), 64'd4);
        chk("rec_top", 64'(ras_if.top_ra_o), 64'h40);
`endif

        for (int n = 0; n < 600; n++) begin
            int unsigned r;
            logic [AW-1:0] d;
            r = $urandom_range(0, 99);
            d = ($urandom_range(0, 1) == 0) ? AW'(16'h0040 + $urandom_range(0, 1)) : AW'($urandom);
            hist.push_back(m_ckpt());
            if (hist.size() > 8) void'(hist.pop_front());
            if (r < 2)
                drive("rnd_rst", 1, $urandom_range(0, 1) == 1, 1, 0, d, 1, hist[0]);
            else if (r < 5)
                drive("rnd_flush", 0, 1, $urandom_range(0, 1) == 1, 0, d, 1, hist[0]);
            else if (r < 14)
                drive("rnd_restore", 0, 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, d, 1,
                      hist[$urandom_range(0, hist.size() - 1)]);
            else
                drive("rnd_op", 0, 0, $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0, d, 0, '0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sy_ppl_spec_ras.md
# sy_ppl_spec_ras

Speculative return-address stack for the fronted branch predictor: a circular buffer with a top-of-stack pointer and occupancy counter, overwrite-on-overflow and checkpoint/restore repair. The fronted snapshots the stack state with each predicted call/return. The backend restores it on a mispredict, so wrong-path pushes and pops do not corrupt the stack. It sits beside the BTB/BHT and supplies the predicted target for returns.

## Interface
- `DEPTH`, 8: number of entries; power of two, ≥2. `PTR_W = $clog2(DEPTH)`, `CNT_W = $clog2(DEPTH+1)`.
- `RCNT_W`, 2: width of the per-entry recursion counter. Used only when `SY_RAS_RCNT_EN` is defined.
- `CKPT_W`, derived: `CNT_W + PTR_W + AWTH` (+`RCNT_W` with the macro). Field order MSB→LSB is {count, ptr, ra[, rcnt]}.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset; one clock; reset is synchronous and active-high.
- `flush_i` in 1: clear the whole stack.
- `push_i` in 1: predicted call; push `data_i`.
- `pop_i` in 1: predicted return; pop the top.
- `data_i` in AWTH: return address to push.
- `top_vld_o` out 1: stack non-empty (count≠0).
- `top_ra_o` out AWTH: address at `entry[ptr]`; 0 when empty.
- `ckpt_o` out CKPT_W: snapshot of the current registered state.
- `restore_i` in 1: repair the stack from `restore_ckpt_i`.
- `restore_ckpt_i` in CKPT_W: snapshot previously taken from `ckpt_o`.

## Operation
- State: `entry[DEPTH]` {ra, rcnt}, `ptr` (PTR_W), `count` (CNT_W). The top is `entry[ptr]` and is valid iff count>0.
- Priority each cycle: rst_i > flush_i > restore_i > push/pop.
- Reset or flush: ptr=0, count=0, all entries 0. Outputs then read `top_vld_o`=0, `top_ra_o`=0, `ckpt_o`=0.
- Push only:
  - ptr←ptr+1 (mod DEPTH); entry[ptr+1].ra←data_i, rcnt←0.
  - count←min(count+1, DEPTH).
  - On a full stack the oldest entry is silently overwritten.
- Pop only, count>0: ptr←ptr−1 (mod DEPTH), count←count−1. The entry data is left in place.
- Pop only, count=0: no state change.
- Push and pop in the same cycle: entry[ptr].ra←data_i, rcnt←0. ptr is unchanged. count←max(count,1).
- Restore:
  - ptr←ckpt.ptr, count←ckpt.count.
  - entry[ckpt.ptr].ra←ckpt.ra (and rcnt←ckpt.rcnt with the macro).
  - push_i and pop_i in the same cycle are ignored.
  - Other entries are not restored; deeper corruption is an accepted loss.
- Counter arithmetic: ptr wraps modulo DEPTH; count saturates at DEPTH and at 0.

## Timing
- All state is registered. Outputs are combinational from registered state only, with no input→output path.
- A push, pop, restore or flush in cycle N is visible on the outputs in cycle N+1.
- `ckpt_o` in cycle N reflects the state before that cycle's push/pop. The fronted pairs it with the prediction made in cycle N.
- No handshake; every request is accepted every cycle.
- rst_i mid-operation: cleared on the next edge regardless of the other inputs.

## Configuration
- `SY_RAS_RCNT_EN` defined: recursion compression.
  - Push only, when count>0, data_i==entry[ptr].ra and rcnt<2^RCNT_W−1: rcnt←rcnt+1, ptr and count unchanged.
  - Push only at saturated rcnt: a normal push.
  - Pop only, when rcnt>0: rcnt←rcnt−1, ptr and count unchanged.
  - Push+pop: rcnt←0.
- `SY_RAS_RCNT_EN` undefined: rcnt storage and logic are absent, the `ckpt_o` field is omitted, and every push allocates an entry.

## Test plan
- Reset → `top_vld_o`=0, `top_ra_o`=0, `ckpt_o`=0. Then push 0x100, 0x200 → next cycle top=0x200; one pop → top=0x100, `top_vld_o`=1.
- DEPTH=4: push 0x10,0x20,0x30,0x40,0x50 → count=4, top=0x50. Four pops return 0x50,0x40,0x30,0x20. A fifth pop leaves count=0 and `top_vld_o`=0.
- Pop on empty → no change, `top_vld_o` stays 0. Push+pop with 0xAA on a stack with top 0x30 → top=0xAA, count unchanged. Push+pop on empty → count=1, top=0xAA.
- Checkpoint at top 0x20 (count=2); then wrong-path push 0x70 and pop ×2; restore with push_i=1 → top=0x20, count=2, and the push is ignored.
- flush_i with push_i in the same cycle → stack empty next cycle. rst_i with restore_i → all zero.
- With `SY_RAS_RCNT_EN`, RCNT_W=2: push 0x40 ×5 → count=2, the first entry holds rcnt=3. Five pops each return 0x40 and the stack ends empty. Without the macro, DEPTH=4, the same sequence gives count=4 after five pushes.
